fpm_norm_round: RTL and testbench
=================================

Name: fpm_norm_round

Overview:
- Registered normalise/round stage sitting directly downstream of the 24x24 mantissa multiplier in the FP32 multiply datapath.
- Consumes the raw 48-bit significand product, the result sign, the raw exponent-field sum and an operand class code.
- Produces an IEEE-754 binary32 result with round-to-nearest-even, overflow to infinity, underflow flush-to-zero and special-value override.
- Two-stage pipeline with a valid/ready handshake on both sides, replacing the combinational truncate-style normaliser.

Parameters:
- BIAS, 127, exponent bias subtracted from the exponent-field sum.
- EXP_W, 11, internal signed exponent width; must cover -127..+384.

Ports:
- clk  in  1  clock; everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has a product this cycle.
- in_ready  out  1  this stage accepts the product this cycle.
- in_sign  in  1  result sign, already XORed upstream.
- in_exp_sum  in  9  exponent field a plus exponent field b, unsigned 0..510.
- in_product  in  48  unsigned significand product, hidden bits included.
- in_class  in  2  fpm_pkg::fp_class_t: 00 NORM, 01 ZERO, 10 INF, 11 NAN.
- out_valid  out  1  out_result is valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  32  {sign, exp[7:0], mant[22:0]}.

Behaviour:
- Reset:
  - S1 valid, S2 valid and out_valid are 0.
  - out_result is 32'h0.
  - in_ready is 1 in the first cycle after reset deasserts.
  - Reset during a stall discards all in-flight items.
- Advance rule: adv = !out_valid | out_ready; in_ready = adv. When adv=0, both stages hold all registers unchanged. Transfer happens on in_valid & in_ready, and on out_valid & out_ready.
- Latency: 2 cycles from accept to out_valid with no stall; throughput 1 per cycle.
- Stage S1 (normalise, registered):
  - If product[47]=1: mant = product[46:24], g = product[23], s = |product[22:0], e = exp_sum - BIAS + 1.
  - Otherwise: mant = product[45:23], g = product[22], s = |product[21:0], e = exp_sum - BIAS.
  - e is signed EXP_W; sign and class are carried alongside.
- Stage S2 (round/pack, registered into out_result):
  - Round increment: inc = g & (s | mant[0]).
  - Add: {c, m} = mant + inc. If c=1, m = 0 and e = e + 1.
  - Pack priority:
    - class NAN -> 32'h7FC00000, sign forced 0.
    - class INF -> {sign, 8'hFF, 0}.
    - class ZERO -> {sign, 31'h0}.
    - e >= 255 -> {sign, 8'hFF, 0}.
    - e <= 0 -> {sign, 31'h0} (flush; no subnormal output).
    - otherwise {sign, e[7:0], m}.
  - Upstream resolves INF*ZERO to NAN.
- Product with bits 47 and 46 both zero occurs only with class ZERO; it is ignored in that case.
- Simultaneous accept and emit in one cycle is legal and loses no data.

Optional Feature:
- FPM_EXC_FLAGS_EN defined:
  - Adds output out_flags[2:0] = {overflow, underflow, inexact}, registered alongside out_result and reset to 0.
  - overflow: e >= 255 on a NORM item.
  - underflow: e <= 0 on a NORM item.
  - inexact: g | s | overflow | underflow on a NORM item.
- FPM_EXC_FLAGS_EN undefined: the port is absent; result behaviour is identical.

Decomposition:
- fpm_pkg holds:
  - fp_class_t enum.
  - BIAS_C = 127, EXP_FIELD_W = 8, MANT_W = 23, PROD_W = 48.
  - QNAN_C = 32'h7FC00000.
  - packed struct fpm_s1_t {sign, class, e, mant, g, s}.
- One sub-module: fpm_round_rne, a combinational rounder taking (mant, g, s, e) and returning (m, e_adj). Instantiated in S2.

Test Plan:
- Exact product, no stall: exp_sum=278, product=48'h4000_0000_0000, sign 0, NORM -> out_result=32'h4B800000 two cycles after accept. Second case: exp_sum=254, product=48'h9000_0000_0000 -> 32'h40100000.
- Ties to even, exp_sum=254, NORM:
  - product=48'h4000_0040_0000 -> 32'h3F800000 (tie, even, no increment).
  - product=48'h4000_00C0_0000 -> 32'h3F800002 (tie, odd, round up).
- Rounding carry: exp_sum=254, product=48'h7FFF_FFC0_0000 -> 32'h40000000.
- Range limits, product=48'h4000_0000_0000:
  - exp_sum=400, sign 0 -> 32'h7F800000.
  - exp_sum=100, sign 1 -> 32'h80000000.
- Specials: class NAN with sign 1 -> 32'h7FC00000; class INF with sign 1 -> 32'hFF800000; class ZERO with sign 0 -> 32'h00000000.
- Back-pressure: stream 4 back-to-back items, out_ready=0 for cycles 3-5.
  - in_ready falls while out_valid=1 and out_ready=0.
  - out_result holds stable through the stall.
  - All 4 results emerge in order with no duplicates or loss.
  - Reset asserted mid-stall clears out_valid the next cycle.

Source files
------------

// File: rtl/fpm_pkg.sv
// Shared types and constants for the FP32 multiply normalise/round stage.
package fpm_pkg;

  typedef enum logic [1:0] {
    CLS_NORM = 2'b00,
    CLS_ZERO = 2'b01,
    CLS_INF  = 2'b10,
    CLS_NAN  = 2'b11
  } fp_class_t;

  localparam int BIAS_C      = 127;
  localparam int EXP_FIELD_W = 8;
  localparam int MANT_W      = 23;
  localparam int PROD_W      = 48;
  localparam int EXP_W_C     = 11;

  localparam logic [31:0] QNAN_C = 32'h7FC0_0000;

  typedef struct packed {
    logic                       sign;
    fp_class_t                  cls;
    logic signed [EXP_W_C-1:0]  e;
    logic [MANT_W-1:0]          mant;
    logic                       g;
    logic                       s;
  } fpm_s1_t;

endpackage

// File: rtl/fpm_round_rne.sv
// Combinational round-to-nearest-even on a normalised 23-bit fraction.
module fpm_round_rne
  import fpm_pkg::*;
#(
  parameter int EXP_W = EXP_W_C
) (
  input  logic [MANT_W-1:0]       mant,
  input  logic                    g,
  input  logic                    s,
  input  logic signed [EXP_W-1:0] e,
  output logic [MANT_W-1:0]       m,
  output logic signed [EXP_W-1:0] e_adj
);

  logic              inc;
  logic [MANT_W:0]   sum;

  always_comb begin
    inc   = g & (s | mant[0]);
    sum   = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
    // A carry out means 1.111..1 rounded up to 10.0, so bump the exponent.
    m     = sum[MANT_W] ? '0 : sum[MANT_W-1:0];
    e_adj = e + $signed({{(EXP_W-1){1'b0}}, sum[MANT_W]});
  end

endmodule

// File: rtl/fpm_norm_round.sv
// Two-stage normalise (S1) and round/pack (S2) pipeline for the FP32 multiplier.
// Optional exception flags output is enabled with `define FPM_EXC_FLAGS_EN.
module fpm_norm_round
  import fpm_pkg::*;
#(
  parameter int BIAS  = BIAS_C,
  parameter int EXP_W = EXP_W_C
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [8:0]           in_exp_sum,
  input  logic [PROD_W-1:0]    in_product,
  input  logic [1:0]           in_class,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef FPM_EXC_FLAGS_EN
  output logic [2:0]           out_flags,
`endif
  output logic [31:0]          out_result
);

  localparam logic signed [EXP_W-1:0] E_MAX  = EXP_W'(255);
  localparam logic signed [EXP_W-1:0] E_ZERO = '0;

  logic        adv;
  logic        s1_valid_q, s1_valid_d;
  fpm_s1_t     s1_q, s1_d, s1_norm;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q, out_result_d, packed_res;
  logic [2:0]  flags_q, flags_d, flags_calc;

  logic signed [EXP_W-1:0] e_norm;
  logic signed [EXP_W-1:0] e_adj;
  logic [MANT_W-1:0]       m_rnd;
  logic                    is_norm, ovf, unf;

  // Normalise: the product of two 1.x significands lies in [1,4).
  always_comb begin
    e_norm = $signed(EXP_W'(in_exp_sum)) - $signed(EXP_W'(BIAS))
           + $signed({{(EXP_W-1){1'b0}}, in_product[47]});
    s1_norm      = '0;
    s1_norm.sign = in_sign;
    s1_norm.cls  = fp_class_t'(in_class);
    s1_norm.e    = e_norm;
    if (in_product[47]) begin
      s1_norm.mant = in_product[46:24];
      s1_norm.g    = in_product[23];
      s1_norm.s    = |in_product[22:0];
    end else begin
      s1_norm.mant = in_product[45:23];
      s1_norm.g    = in_product[22];
      s1_norm.s    = |in_product[21:0];
    end
  end

  fpm_round_rne #(.EXP_W(EXP_W)) u_round (
    .mant  (s1_q.mant),
    .g     (s1_q.g),
    .s     (s1_q.s),
    .e     (s1_q.e),
    .m     (m_rnd),
    .e_adj (e_adj)
  );

  always_comb begin
    is_norm = (s1_q.cls == CLS_NORM);
    ovf     = is_norm && (e_adj >= E_MAX);
    unf     = is_norm && (e_adj <= E_ZERO);
    flags_calc = {ovf, unf, is_norm & (s1_q.g | s1_q.s | ovf | unf)};
    unique case (s1_q.cls)
      CLS_NAN:  packed_res = QNAN_C;
      CLS_INF:  packed_res = {s1_q.sign, 8'hFF, 23'h0};
      CLS_ZERO: packed_res = {s1_q.sign, 31'h0};
      default: begin
        if (ovf)      packed_res = {s1_q.sign, 8'hFF, 23'h0};
        else if (unf) packed_res = {s1_q.sign, 31'h0};
        else          packed_res = {s1_q.sign, e_adj[7:0], m_rnd};
      end
    endcase
  end

  // Whole pipe freezes when the output is held by downstream.
  always_comb begin
    adv          = !out_valid_q | out_ready;
    s1_valid_d   = s1_valid_q;
    s1_d         = s1_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    flags_d      = flags_q;
    if (adv) begin
      s1_valid_d  = in_valid;
      if (in_valid) s1_d = s1_norm;
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_result_d = packed_res;
        flags_d      = flags_calc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      flags_q      <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_q         <= s1_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      flags_q      <= flags_d;
    end
  end

  assign in_ready   = adv;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
`ifdef FPM_EXC_FLAGS_EN
  assign out_flags  = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^flags_q;
`endif

endmodule

// File: tb/tb_fpm_norm_round.sv
// Scoreboard bench for fpm_norm_round against an integer-arithmetic IEEE model.
module tb_fpm_norm_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [8:0]  in_exp_sum;
  logic [47:0] in_product;
  logic [1:0]  in_class;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  act_flags;

  int errors = 0;
  int checks = 0;
  int txn    = 0;
  logic [34:0] exp_q[$];

  logic        prev_stall = 1'b0;
  logic [31:0] prev_result = '0;

  always #5 clk = ~clk;

  fpm_norm_round dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp_sum (in_exp_sum),
    .in_product (in_product),
    .in_class   (in_class),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef FPM_EXC_FLAGS_EN
    .out_flags  (act_flags),
`endif
    .out_result (out_result)
  );

`ifndef FPM_EXC_FLAGS_EN
  assign act_flags = 3'b000;
`endif

  // Reference: scale the product to a 24-bit significand and round the
  // discarded remainder against one half, ties to an even significand.
  function automatic logic [34:0] ref_model(input logic sgn, input logic [8:0] es,
                                            input logic [47:0] p, input logic [1:0] cls);
    longint e;
    longint unsigned q, rem, half;
    int sh;
    logic [2:0]  fl;
    logic [31:0] r;
    logic [63:0] ev;
    fl = 3'b000;
    case (cls)
      2'b11: r = 32'h7FC0_0000;
      2'b10: r = {sgn, 8'hFF, 23'h0};
      2'b01: r = {sgn, 31'h0};
      default: begin
        sh   = p[47] ? 24 : 23;
        e    = longint'(es) - 127 + (p[47] ? 1 : 0);
        q    = 64'(p) >> sh;
        rem  = 64'(p) - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
          q = q >> 1;
          e = e + 1;
        end
        ev = 64'(e);
        if (e >= 255) begin
          r = {sgn, 8'hFF, 23'h0}; fl = 3'b101;
        end else if (e <= 0) begin
          r = {sgn, 31'h0}; fl = 3'b011;
        end else begin
          r = {sgn, ev[7:0], q[22:0]}; fl = {2'b00, rem != 0};
        end
      end
    endcase
`ifndef FPM_EXC_FLAGS_EN
    fl = 3'b000;
`endif
    return {fl, r};
  endfunction

  // Issue side: record the expected response whenever a transfer will occur.
  always @(negedge clk) begin
    if (!reset && in_valid && in_ready)
      exp_q.push_back(ref_model(in_sign, in_exp_sum, in_product, in_class));
  end

  // Monitor: protocol checks plus in-order result comparison.
  always @(negedge clk) begin
    logic [34:0] e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL in_ready: got %b want %b", in_ready, (!out_valid || out_ready));
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== prev_result) begin
          errors++;
          $display("FAIL stall_hold: got v=%b r=%h want v=1 r=%h", out_valid, out_result, prev_result);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        txn++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h want none", out_result);
        end else begin
          e = exp_q.pop_front();
          if (out_result !== e[31:0] || act_flags !== e[34:32]) begin
            errors++;
            $display("FAIL result txn %0d: got %h flags %b want %h flags %b",
                     txn, out_result, act_flags, e[31:0], e[34:32]);
          end else begin
            $display("txn %0d result=%h flags=%b ok", txn, out_result, act_flags);
          end
        end
      end
      prev_stall  = out_valid && !out_ready;
      prev_result = out_result;
    end
  end

  task automatic send(input logic sgn, input logic [8:0] es, input logic [47:0] p, input logic [1:0] cls);
    int n;
    in_valid = 1'b1; in_sign = sgn; in_exp_sum = es; in_product = p; in_class = cls;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic rand_item();
    logic [47:0] p;
    logic [8:0]  es;
    logic [1:0]  cls;
    p   = {16'($urandom), 32'($urandom)};
    if ($urandom_range(3) == 0) p[21:0] = '0;
    if ($urandom_range(5) == 0) p[22:0] = 23'h40_0000;
    cls = ($urandom_range(7) < 5) ? 2'b00 : 2'($urandom);
    if (cls == 2'b00 && !p[47] && !p[46]) p[46] = 1'b1;
    case ($urandom_range(3))
      0: es = 9'($urandom_range(0, 510));
      1: es = 9'($urandom_range(120, 135));
      2: es = 9'($urandom_range(375, 385));
      default: es = 9'($urandom_range(200, 300));
    endcase
    send(1'($urandom), es, p, cls);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp_sum = '0;
    in_product = '0; in_class = 2'b00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%b r=%h rdy=%b want v=0 r=00000000 rdy=1",
               out_valid, out_result, in_ready);
    end
    @(posedge clk); #1;

    // Directed cases.
    send(1'b0, 9'd278, 48'h4000_0000_0000, 2'b00);
    send(1'b0, 9'd254, 48'h9000_0000_0000, 2'b00);
    send(1'b0, 9'd254, 48'h4000_0040_0000, 2'b00);
    send(1'b0, 9'd254, 48'h4000_00C0_0000, 2'b00);
    send(1'b0, 9'd254, 48'h7FFF_FFC0_0000, 2'b00);
    send(1'b0, 9'd400, 48'h4000_0000_0000, 2'b00);
    send(1'b1, 9'd100, 48'h4000_0000_0000, 2'b00);
    send(1'b1, 9'd254, 48'h4000_0000_0000, 2'b11);
    send(1'b1, 9'd254, 48'h4000_0000_0000, 2'b10);
    send(1'b0, 9'd254, 48'h0000_0000_0000, 2'b01);
    drain();

    // Four back-to-back items with a three-cycle output stall.
    fork
      begin
        send(1'b0, 9'd254, 48'h4000_0000_0000, 2'b00);
        send(1'b1, 9'd260, 48'h9000_0000_0000, 2'b00);
        send(1'b0, 9'd254, 48'h4000_00C0_0000, 2'b00);
        send(1'b1, 9'd250, 48'h7FFF_FFC0_0000, 2'b00);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random back-pressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          rand_item();
          if ($urandom_range(3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
      end
      begin
        for (int k = 0; k < 1200; k++) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(9) < 7);
        end
      end
    join_any
    disable fork;
    drain();

    // Reset in the middle of a stall discards everything in flight.
    out_ready = 1'b0;
    send(1'b0, 9'd254, 48'h4000_0000_0000, 2'b00);
    send(1'b0, 9'd255, 48'h4000_0000_0000, 2'b00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0) begin
      errors++;
      $display("FAIL midstall_reset: got v=%b r=%h want v=0 r=00000000", out_valid, out_result);
    end
    @(posedge clk); #1 reset = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got v=%b want v=0", out_valid);
    end
    send(1'b0, 9'd278, 48'h4000_0000_0000, 2'b00);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
